// File: rtl/convertidor_scheduler.sv
// convertidor_scheduler
// Shares one parallel-to-serial converter among N requesters. A round-robin
// arbiter picks a winner in IDLE, the winner's word is loaded onto P_IN with
// a one-cycle S_START pulse, P_IN is held for the WORD_W-cycle shift-out, and
// GAP idle cycles follow before the next arbitration.
//
// Configuration macro: SCHED_PRIO0_EN
//   defined   - requester 0 wins whenever it requests in IDLE; a grant to
//               requester 0 leaves the round-robin pointer where it was.
//   undefined - pure round-robin over all N requesters.
//
// Ports
//   CLK      in   rising-edge clock
//   RESET    in   asynchronous active-low reset
//   REQ      in   [N]         level request per requester
//   DATA_IN  in   [N*WORD_W]  word of requester i at [i*WORD_W +: WORD_W]
//   GNT      out  [N]         one-hot pulse, word of requester i captured
//   P_IN     out  [WORD_W]    word to converter, held from LOAD to end of SHIFT
//   S_START  out  1           pulse to converter, coincident with LOAD
//   BUSY     out  1           high in LOAD, SHIFT and GAP
//   CUR_ID   out  [clog2(N)]  index of the requester being served
//   DONE     out  1           pulse in the first cycle after the last SHIFT cycle
module convertidor_scheduler #(
    parameter int N      = 4,
    parameter int WORD_W = 32,
    parameter int GAP    = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [N-1:0]            REQ,
    input  logic [N*WORD_W-1:0]     DATA_IN,
    output logic [N-1:0]            GNT,
    output logic [WORD_W-1:0]       P_IN,
    output logic                    S_START,
    output logic                    BUSY,
    output logic [$clog2(N)-1:0]    CUR_ID,
    output logic                    DONE
);

    localparam int IDW = $clog2(N);
    // One counter serves both the SHIFT and the GAP phase.
    localparam int CW  = $clog2(WORD_W + GAP + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]      cur_id_q, cur_id_d;
    logic [N-1:0]        gnt_q, gnt_d;
    logic [WORD_W-1:0]   p_in_q, p_in_d;
    logic                s_start_q, s_start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                found_s;
    logic                prio0_s;
    logic [IDW-1:0]      win_s;
    logic [IDW-1:0]      idx_s;
    logic [IDW:0]        sum_s;
    logic [WORD_W-1:0]   win_data_s;

    // Round-robin search starting at the pointer; the index wraps modulo N.
    always_comb begin
        found_s = 1'b0;
        prio0_s = 1'b0;
        win_s   = {IDW{1'b0}};
        idx_s   = {IDW{1'b0}};
        sum_s   = {(IDW+1){1'b0}};
        for (int i = 0; i < N; i++) begin
            sum_s = {1'b0, ptr_q} + (IDW+1)'(i);
            if (sum_s >= (IDW+1)'(N)) begin
                idx_s = IDW'(sum_s - (IDW+1)'(N));
            end else begin
                idx_s = IDW'(sum_s);
            end
            if (!found_s && REQ[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
`ifdef SCHED_PRIO0_EN
        if (REQ[0]) begin
            prio0_s = 1'b1;
            win_s   = {IDW{1'b0}};
        end else begin
            prio0_s = 1'b0;
        end
`endif
    end

    // Word of the current winner.
    always_comb begin
        win_data_s = {WORD_W{1'b0}};
        for (int j = 0; j < N; j++) begin
            if (IDW'(j) == win_s) begin
                win_data_s = DATA_IN[j*WORD_W +: WORD_W];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Next-state and next-output logic; BUSY follows the state being entered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        cur_id_d  = cur_id_q;
        p_in_d    = p_in_q;
        gnt_d     = {N{1'b0}};
        s_start_d = 1'b0;
        done_d    = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d   = ST_LOAD;
                    gnt_d     = {{(N-1){1'b0}}, 1'b1} << win_s;
                    s_start_d = 1'b1;
                    p_in_d    = win_data_s;
                    cur_id_d  = win_s;
                    busy_d    = 1'b1;
                    if (prio0_s) begin
                        ptr_d = ptr_q;
                    end else if (win_s == IDW'(N-1)) begin
                        ptr_d = {IDW{1'b0}};
                    end else begin
                        ptr_d = win_s + IDW'(1);
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
                cnt_d   = CW'(WORD_W - 1);
                busy_d  = 1'b1;
            end
            ST_SHIFT: begin
                if (cnt_q == CW'(0)) begin
                    done_d = 1'b1;
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = CW'(GAP - 1);
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CW'(0)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer immediately.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CW{1'b0}};
            ptr_q     <= {IDW{1'b0}};
            cur_id_q  <= {IDW{1'b0}};
            gnt_q     <= {N{1'b0}};
            p_in_q    <= {WORD_W{1'b0}};
            s_start_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            cur_id_q  <= cur_id_d;
            gnt_q     <= gnt_d;
            p_in_q    <= p_in_d;
            s_start_q <= s_start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign GNT     = gnt_q;
    assign P_IN    = p_in_q;
    assign S_START = s_start_q;
    assign BUSY    = busy_q;
    assign CUR_ID  = cur_id_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_convertidor_scheduler.sv
// Directed bench for convertidor_scheduler at N=4, WORD_W=32, GAP=1.
module tb_convertidor_scheduler;

    logic         CLK;
    logic         RESET;
    logic [3:0]   REQ;
    logic [127:0] DATA_IN;
    logic [3:0]   GNT;
    logic [31:0]  P_IN;
    logic         S_START;
    logic         BUSY;
    logic [1:0]   CUR_ID;
    logic         DONE;

    int checks = 0;
    int errors = 0;

    convertidor_scheduler #(.N(4), .WORD_W(32), .GAP(1)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .DATA_IN(DATA_IN),
        .GNT(GNT), .P_IN(P_IN), .S_START(S_START), .BUSY(BUSY),
        .CUR_ID(CUR_ID), .DONE(DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Steps until S_START is seen; n is the number of cycles taken (capped).
    task automatic wait_start(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!S_START && n < 200);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY && n < 200) begin
            step(1);
            n++;
        end
        chk("wait_idle_timeout", 32'(n < 200), 32'd1);
    endtask

    initial begin
        int busy_cnt, done_at, done_cnt, extra, n, p_bad, exp_id;
        logic [31:0] w [4];

        RESET   = 1'b1;
        REQ     = 4'b0000;
        DATA_IN = 128'd0;
        #2 RESET = 1'b0;
        #1;
        chk("rst_gnt",    32'(GNT),     32'd0);
        chk("rst_start",  32'(S_START), 32'd0);
        chk("rst_pin",    P_IN,         32'd0);
        chk("rst_busy",   32'(BUSY),    32'd0);
        chk("rst_curid",  32'(CUR_ID),  32'd0);
        chk("rst_done",   32'(DONE),    32'd0);
        step(2);
        RESET = 1'b1;

        // Single request from requester 1.
        REQ = 4'b0010;
        DATA_IN[63:32] = 32'hA5A5_0F0F;
        step(1);
        chk("t2_gnt",   32'(GNT),     32'h2);
        chk("t2_start", 32'(S_START), 32'd1);
        chk("t2_pin",   P_IN,         32'hA5A5_0F0F);
        chk("t2_curid", 32'(CUR_ID),  32'd1);
        chk("t2_busy0", 32'(BUSY),    32'd1);
        REQ = 4'b0000;
        busy_cnt = 0; done_at = 0; done_cnt = 0; extra = 0;
        for (int c = 1; c <= 40; c++) begin
            step(1);
            if (BUSY) busy_cnt++;
            if (DONE) begin
                done_at = c;
                done_cnt++;
            end
            if (GNT != 4'b0000 || S_START) extra++;
        end
        chk("t2_busy_len", 32'(busy_cnt + 1), 32'd34);
        chk("t2_done_at",  32'(done_at),      32'd33);
        chk("t2_done_cnt", 32'(done_cnt),     32'd1);
        chk("t2_no_extra", 32'(extra),        32'd0);
        chk("t2_pin_hold", P_IN,              32'hA5A5_0F0F);

        // Fresh reset so the pointer starts at 0, then all four request.
        RESET = 1'b0;
        step(1);
        RESET = 1'b1;
        w[0] = 32'hAAAA_0000; w[1] = 32'hBBBB_0001;
        w[2] = 32'hCCCC_0002; w[3] = 32'hDDDD_0003;
        DATA_IN = {w[3], w[2], w[1], w[0]};
        REQ = 4'b1111;
        wait_start(n);
        chk("t3_gnt0",  32'(GNT),    32'h1);
        chk("t3_curid0", 32'(CUR_ID), 32'd0);
        chk("t3_pin0",  P_IN,        w[0]);
        for (int k = 1; k <= 4; k++) begin
`ifdef SCHED_PRIO0_EN
            exp_id = 0;
`else
            exp_id = k % 4;
`endif
            wait_start(n);
            chk("t3_period", 32'(n),      32'd35);
            chk("t3_gnt",    32'(GNT),    32'(1 << exp_id));
            chk("t3_curid",  32'(CUR_ID), 32'(exp_id));
            chk("t3_pin",    P_IN,        w[exp_id]);
        end
        REQ = 4'b0000;
        wait_idle();

        // Changes during SHIFT must not disturb P_IN or the current word.
        DATA_IN[31:0] = 32'h1234_5678;
        REQ = 4'b0001;
        wait_start(n);
        chk("t4_gnt", 32'(GNT), 32'h1);
        chk("t4_pin", P_IN,     32'h1234_5678);
        REQ = 4'b0000;
        step(5);
        REQ = 4'b0100;
        DATA_IN[31:0] = 32'hDEAD_BEEF;
        n = 0; p_bad = 0;
        do begin
            step(1);
            n++;
            if (!S_START && P_IN !== 32'h1234_5678) p_bad++;
        end while (!S_START && n < 200);
        chk("t4_pin_stable", 32'(p_bad), 32'd0);
        chk("t4_wait",       32'(n),     32'd30);
        chk("t4_gnt2",       32'(GNT),   32'h4);
        chk("t4_pin2",       P_IN,       w[2]);
        REQ = 4'b0000;

        // Reset at SHIFT cycle 10 aborts the word without DONE.
        step(10);
        RESET = 1'b0;
        #1;
        chk("t1_gnt",   32'(GNT),     32'd0);
        chk("t1_start", 32'(S_START), 32'd0);
        chk("t1_pin",   P_IN,         32'd0);
        chk("t1_busy",  32'(BUSY),    32'd0);
        chk("t1_curid", 32'(CUR_ID),  32'd0);
        chk("t1_done",  32'(DONE),    32'd0);
        done_cnt = 0;
        for (int c = 0; c < 2; c++) begin
            step(1);
            if (DONE) done_cnt++;
        end
        RESET = 1'b1;
        REQ = 4'b1000;
        step(1);
        if (DONE) done_cnt++;
        chk("t5_no_done", 32'(done_cnt), 32'd0);
        chk("t5_gnt",     32'(GNT),      32'h8);
        chk("t5_curid",   32'(CUR_ID),   32'd3);
        chk("t5_pin",     P_IN,          w[3]);
        REQ = 4'b0000;
        step(1);
        wait_idle();

        // Grant requester 1 so the pointer sits at 2, then 0 and 2 compete.
        REQ = 4'b0010;
        wait_start(n);
        chk("t6_pre_gnt", 32'(GNT), 32'h2);
        REQ = 4'b0000;
        step(1);
        wait_idle();
        REQ = 4'b0101;
        wait_start(n);
        chk("t6_lat", 32'(n), 32'd1);
`ifdef SCHED_PRIO0_EN
        chk("t6_gnt", 32'(GNT), 32'h1);
`else
        chk("t6_gnt", 32'(GNT), 32'h4);
`endif
        REQ = 4'b0000;
        step(1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
